l1_write_buffer: RTL and testbench

- Posted-write buffer between the L1 data cache memory port and the memory bus.
- Accepts write-through stores in one cycle, which removes the cache's memory-latency stall on writes. Drains stores to memory in FIFO order in the background.
- Reads (cache line refills) pass through only after the buffer is empty. Memory therefore always sees every older store before a refill read.

---
 rtl/l1_cache_pkg.sv | 19 +
 rtl/l1_write_buffer_if.sv | 37 +++
 rtl/wb_fifo.sv | 46 ++++
 rtl/l1_write_buffer.sv | 116 +++++++++++
 tb/tb_l1_write_buffer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and defaults for the L1 posted-write buffer.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } wb_state_e;

  localparam int WB_DEPTH       = 4;
  localparam int WB_ADDR_WIDTH  = 32;
  localparam int WB_DATA_WIDTH  = 32;
  localparam int WB_ENTRY_WIDTH = WB_ADDR_WIDTH + WB_DATA_WIDTH + WB_DATA_WIDTH / 8;

  function automatic int wb_entry_width(input int addr_width, input int data_width);
    return addr_width + data_width + data_width / 8;
  endfunction

endpackage

// File: rtl/l1_write_buffer_if.sv
// Cache-side and bus-side handshake signals of the write buffer.
interface l1_write_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   cpu_address;
  logic [DATA_WIDTH-1:0]   cpu_write_data;
  logic [DATA_WIDTH/8-1:0] cpu_byte_enable;
  logic                    cpu_write_enable;
  logic                    cpu_request;
  logic [DATA_WIDTH-1:0]   cpu_read_data;
  logic                    cpu_ready;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH-1:0]   mem_write_data;
  logic [DATA_WIDTH/8-1:0] mem_byte_enable;
  logic                    mem_write_enable;
  logic                    mem_request;
  logic [DATA_WIDTH-1:0]   mem_read_data;
  logic                    mem_ready;
  logic                    buffer_empty;

  modport master (
    output cpu_address, cpu_write_data, cpu_byte_enable, cpu_write_enable, cpu_request,
    output mem_read_data, mem_ready,
    input  cpu_read_data, cpu_ready,
    input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_request,
    input  buffer_empty
  );

  modport slave (
    input  cpu_address, cpu_write_data, cpu_byte_enable, cpu_write_enable, cpu_request,
    input  mem_read_data, mem_ready,
    output cpu_read_data, cpu_ready,
    output mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_request,
    output buffer_empty
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO holding posted stores; push is refused when full, pop when empty.
module wb_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = storage[rd_ptr];

  // Pointers wrap by overflow since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) storage[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/l1_write_buffer.sv
// Posted-write buffer: stores retire in one cycle and drain in order; refill reads wait for an empty buffer.
module l1_write_buffer
  import l1_cache_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  l1_write_buffer_if.slave bus
);
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int ENTRY_W = wb_entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  wb_state_e         state;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ENTRY_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              store_accept;
  logic              pop;
  logic              read_done;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BE_W-1:0]       head_be;

  assign store_accept = bus.cpu_request & bus.cpu_write_enable & ~fifo_full;
  assign pop          = (state == S_WR) & bus.mem_ready & ~fifo_empty;
  assign read_done    = (state == S_RD) & bus.mem_ready;
  assign {head_addr, head_data, head_be} = head;

  wb_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (store_accept),
    .pop  (pop),
    .wdata({bus.cpu_address, bus.cpu_write_data, bus.cpu_byte_enable}),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // A store landing in IDLE starts the drain right away so the bus sees it next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((fifo_count != '0) || store_accept) begin
            state     <= S_WR;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end else if (bus.cpu_request && !bus.cpu_write_enable) begin
            state     <= S_RD;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end
        end
        S_WR: begin
          if (bus.mem_ready && (fifo_count <= CNT_W'(1))) begin
            state     <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        S_RD: begin
          if (bus.mem_ready) begin
            state     <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_address     = '0;
    bus.mem_write_data  = '0;
    bus.mem_byte_enable = '0;
    case (state)
      S_WR: begin
        bus.mem_address     = head_addr;
        bus.mem_write_data  = head_data;
        bus.mem_byte_enable = head_be;
      end
      S_RD: begin
        bus.mem_address     = bus.cpu_address;
        bus.mem_byte_enable = '1;
      end
      default: ;
    endcase
  end

  assign bus.mem_request      = mem_req_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.cpu_ready        = store_accept | read_done;
  assign bus.cpu_read_data    = read_done ? bus.mem_read_data : '0;
  assign bus.buffer_empty     = (fifo_count == '0) && (state == S_IDLE);
endmodule

// File: tb/tb_l1_write_buffer.sv
// Randomised and directed scoreboard bench for l1_write_buffer.
module tb_l1_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } bus_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   model_count = 0;
  int   last_pop_cyc = -1;
  bit   hold_bus = 1'b0;
  bit   lat_rand = 1'b0;
  bit   rd_data_rand = 1'b0;
  int   cur_lat = 0;
  int   wait_cnt = 0;
  logic [31:0] next_rd_data = 32'h0;
  bus_txn_t exp_q[$];

  l1_write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbif ();

  l1_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(wbif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus slave: completes a request after cur_lat wait cycles, or never while hold_bus is set.
  initial begin
    wbif.mem_ready = 1'b0;
    wbif.mem_read_data = '0;
    forever begin
      @(posedge clk);
      #2;
      wbif.mem_ready = 1'b0;
      wbif.mem_read_data = '0;
      if (rst || !wbif.mem_request || hold_bus) begin
        wait_cnt = 0;
      end else if (wait_cnt < cur_lat) begin
        wait_cnt++;
      end else begin
        wbif.mem_ready = 1'b1;
        wbif.mem_read_data = rd_data_rand ? $urandom : next_rd_data;
        wait_cnt = 0;
        if (lat_rand) cur_lat = $urandom_range(0, 2);
      end
    end
  end

  // Monitor: reference occupancy model plus in-order bus scoreboard.
  always @(negedge clk) begin
    bit exp_acc;
    bit exp_rd_done;
    bit wr_done;
    bus_txn_t t;
    if (rst) begin
      model_count = 0;
    end else begin
      exp_acc = wbif.cpu_request && wbif.cpu_write_enable && (model_count < DEPTH);
      exp_rd_done = wbif.cpu_request && !wbif.cpu_write_enable && wbif.mem_request &&
                    !wbif.mem_write_enable && wbif.mem_ready;
      check("cpu_ready", wbif.cpu_ready, exp_acc || exp_rd_done);
      check("cpu_read_data", wbif.cpu_read_data, exp_rd_done ? wbif.mem_read_data : 32'h0);
      wr_done = wbif.mem_request && wbif.mem_ready && wbif.mem_write_enable;
      if (wbif.mem_request && wbif.mem_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL bus_unexpected: got transfer addr 0x%0h we %0b, expected none", wbif.mem_address,
                   wbif.mem_write_enable);
        end else begin
          t = exp_q.pop_front();
          check("bus_we", wbif.mem_write_enable, t.we);
          check("bus_addr", wbif.mem_address, t.addr);
          check("bus_be", wbif.mem_byte_enable, t.be);
          if (t.we) check("bus_wdata", wbif.mem_write_data, t.data);
        end
        if (wr_done) last_pop_cyc = cyc;
      end
      model_count = model_count + int'(exp_acc) - int'(wr_done);
    end
  end

  task automatic set_lat(input int lat, input bit rnd);
    cur_lat = lat;
    lat_rand = rnd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                          output int waits, output int acc_cyc);
    bit done = 1'b0;
    bus_txn_t t;
    waits = 0;
    acc_cyc = -1;
    wbif.cpu_address = addr;
    wbif.cpu_write_data = data;
    wbif.cpu_byte_enable = be;
    wbif.cpu_write_enable = 1'b1;
    wbif.cpu_request = 1'b1;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (wbif.cpu_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
        t.we = 1'b1; t.addr = addr; t.data = data; t.be = be;
        exp_q.push_back(t);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    wbif.cpu_request = 1'b0;
    wbif.cpu_write_enable = 1'b0;
    if (!done) check("store_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
    bit done = 1'b0;
    bus_txn_t t;
    waits = 0;
    data = '0;
    t.we = 1'b0; t.addr = addr; t.data = '0; t.be = 4'hF;
    exp_q.push_back(t);
    wbif.cpu_address = addr;
    wbif.cpu_write_enable = 1'b0;
    wbif.cpu_request = 1'b1;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (wbif.cpu_ready) begin
        done = 1'b1;
        data = wbif.cpu_read_data;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    wbif.cpu_request = 1'b0;
    if (!done) check("read_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (wbif.buffer_empty && exp_q.size() == 0) break;
      n++;
      @(posedge clk);
      #1;
    end
    if (n < 300) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", n < 300, 1'b1);
  endtask

  initial begin
    int w, w5, ac, ac5;
    logic [31:0] d;
    wbif.cpu_address = '0;
    wbif.cpu_write_data = '0;
    wbif.cpu_byte_enable = '0;
    wbif.cpu_write_enable = 1'b0;
    wbif.cpu_request = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_request", wbif.mem_request, 1'b0);
    check("reset_mem_addr", wbif.mem_address, 32'h0);
    check("reset_cpu_ready", wbif.cpu_ready, 1'b0);
    check("reset_cpu_rdata", wbif.cpu_read_data, 32'h0);
    check("reset_buffer_empty", wbif.buffer_empty, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Single store into an empty buffer, 3-cycle bus.
    set_lat(2, 1'b0);
    do_store(32'h100, 32'hDEADBEEF, 4'hF, w, ac);
    check("t1_ready_same_cycle", w, 0);
    @(negedge clk);
    check("t1_mem_request", wbif.mem_request, 1'b1);
    check("t1_mem_we", wbif.mem_write_enable, 1'b1);
    check("t1_mem_addr", wbif.mem_address, 32'h100);
    @(posedge clk);
    #1;
    wait_empty();
    check("t1_empty", wbif.buffer_empty, 1'b1);

    // Full buffer: fifth store waits for the first pop and lands one cycle later.
    hold_bus = 1'b1;
    set_lat(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_store(32'(i * 4), $urandom, 4'hF, w, ac);
      check("t2_immediate_accept", w, 0);
    end
    fork
      do_store(32'h10, 32'hA5A5_0010, 4'hF, w5, ac5);
      begin
        idle(3);
        hold_bus = 1'b0;
      end
    join
    check("t2_fifth_stalled", w5 > 0, 1'b1);
    check("t2_fifth_after_pop", ac5, last_pop_cyc + 1);
    wait_empty();

    // Read after two stores must follow both writes on the bus.
    set_lat(0, 1'b0);
    rd_data_rand = 1'b0;
    next_rd_data = 32'h12345678;
    do_store(32'h200, 32'h11, 4'hF, w, ac);
    do_store(32'h204, 32'h22, 4'hF, w, ac);
    do_read(32'h200, d, w);
    check("t3_read_data", d, 32'h12345678);
    wait_empty();

    // Read on empty buffer with 2-cycle bus.
    set_lat(1, 1'b0);
    next_rd_data = 32'hCAFEF00D;
    do_read(32'h300, d, w);
    check("t4_read_latency", w, 2);
    check("t4_read_data", d, 32'hCAFEF00D);
    idle(3);
    wait_empty();

    // Partial-lane store passes through untouched.
    set_lat(0, 1'b0);
    do_store(32'h401, 32'h0000AB00, 4'h2, w, ac);
    @(negedge clk);
    check("t5_mem_be", wbif.mem_byte_enable, 4'h2);
    check("t5_mem_wdata", wbif.mem_write_data, 32'h0000AB00);
    @(posedge clk);
    #1;
    wait_empty();

    // Asynchronous reset in the middle of a drain.
    hold_bus = 1'b1;
    do_store(32'h500, 32'h55, 4'hF, w, ac);
    do_store(32'h504, 32'h66, 4'hF, w, ac);
    @(negedge clk);
    check("t6_draining", wbif.mem_request && wbif.mem_write_enable, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_mem_request", wbif.mem_request, 1'b0);
    check("t6_rst_empty", wbif.buffer_empty, 1'b1);
    exp_q.delete();
    hold_bus = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_stale_write", wbif.mem_request, 1'b0);
      @(posedge clk);
      #1;
    end

    // Random mix of stores and reads with random bus latency.
    set_lat(1, 1'b1);
    rd_data_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_read({$urandom_range(0, 16'hFFFF), 2'b00}, d, w);
      end else begin
        do_store($urandom, $urandom, 4'($urandom_range(0, 15)), w, ac);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    wait_empty();
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
